// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C sensor sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT_REQ  = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_POLL_WAIT = 3'd3,
        ST_READ_REQ  = 3'd4,
        ST_READ_WAIT = 3'd5,
        ST_LATCH     = 3'd6
    } state_t;

    // Sensor register map defaults
    localparam logic [6:0] DEF_DEV_ADDR = 7'h68;
    localparam logic [7:0] DEF_INIT_REG = 8'h6B;
    localparam logic [7:0] DEF_INIT_VAL = 8'h00;
    localparam logic [7:0] DEF_DATA_REG = 8'h3B;

    // Transaction payload sizes
    localparam int INIT_NUM_BYTES = 1;
    localparam int READ_NUM_BYTES = 6;

    // Position of each sample byte inside the read burst (big-endian words)
    localparam int IDX_X_HI = 0;
    localparam int IDX_X_LO = 1;
    localparam int IDX_Y_HI = 2;
    localparam int IDX_Y_LO = 3;
    localparam int IDX_Z_HI = 4;
    localparam int IDX_Z_LO = 5;

    // Width of the byte-count field for a master with max_bytes of capacity
    function automatic int numbytes_width(input int max_bytes);
        return $clog2(max_bytes + 2);
    endfunction

endpackage

// File: rtl/i2c_sensor_sequencer_sample_unpack.sv
// Maps six burst-read bytes onto three big-endian 16-bit two's-complement samples.
// Latency: combinational; the parent registers the result.
// Backpressure: none.
module sample_unpack
    import i2c_pkg::*;
#(
    parameter int MAX_BYTES = 6
) (
    input  logic [8*MAX_BYTES-1:0] rdata,
    output logic [15:0]            x,
    output logic [15:0]            y,
    output logic [15:0]            z
);

    // Pick byte k of the master read bus
    function automatic logic [7:0] byte_at(input logic [8*MAX_BYTES-1:0] d, input int k);
        return d[8*k +: 8];
    endfunction

    // High byte first for each axis
    always_comb begin
        x = {byte_at(rdata, IDX_X_HI), byte_at(rdata, IDX_X_LO)};
        y = {byte_at(rdata, IDX_Y_HI), byte_at(rdata, IDX_Y_LO)};
        z = {byte_at(rdata, IDX_Z_HI), byte_at(rdata, IDX_Z_LO)};
    end

endmodule

// File: rtl/i2c_sensor_sequencer.sv
// Drives an I2C master: one config write after reset/error, then periodic 6-byte sample reads.
// Latency: samples strobe one cycle after the master reports read completion.
// Backpressure: start held until the master drops i2c_done; stalls beyond TIMEOUT abort and re-init.
module i2c_sensor_sequencer
    import i2c_pkg::*;
#(
    parameter int         MAX_BYTES = 6,
    parameter logic [6:0] DEV_ADDR  = DEF_DEV_ADDR,
    parameter logic [7:0] INIT_REG  = DEF_INIT_REG,
    parameter logic [7:0] INIT_VAL  = DEF_INIT_VAL,
    parameter logic [7:0] DATA_REG  = DEF_DATA_REG,
    parameter int         POLL_DIV  = 50000,
    parameter int         TIMEOUT   = 20000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 i2c_done,
    input  logic [8*MAX_BYTES-1:0]               i2c_rdata,
    output logic                                 i2c_start,
    output logic                                 i2c_write,
    output logic [6:0]                           i2c_dev_addr,
    output logic [7:0]                           i2c_reg_addr,
    output logic [numbytes_width(MAX_BYTES)-1:0] i2c_num_bytes,
    output logic [8*MAX_BYTES-1:0]               i2c_wdata,
    output logic [15:0]                          accel_x,
    output logic [15:0]                          accel_y,
    output logic [15:0]                          accel_z,
    output logic                                 sample_valid,
    output logic                                 err_timeout,
    output logic                                 overrun,
    output logic [7:0]                           err_count
);

    localparam int NB_W   = numbytes_width(MAX_BYTES);
    localparam int POLL_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic                   start_q, start_d;
    logic                   write_q, write_d;
    logic [7:0]             reg_q, reg_d;
    logic [NB_W-1:0]        num_q, num_d;
    logic [8*MAX_BYTES-1:0] wdata_q, wdata_d;
    logic [15:0]            ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic                   valid_q, valid_d;
    logic                   to_pulse_q, to_pulse_d;
    logic                   overrun_q, overrun_d;
    logic [7:0]             err_cnt_q, err_cnt_d;
    logic [POLL_W-1:0]      poll_cnt_q, poll_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;

    logic        poll_run, tick, in_txn, to_hit;
    logic [15:0] unp_x, unp_y, unp_z;

    sample_unpack #(.MAX_BYTES(MAX_BYTES)) u_unpack (
        .rdata (i2c_rdata),
        .x     (unp_x),
        .y     (unp_y),
        .z     (unp_z)
    );

    // Next-state, request-field, counter and status computation
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        write_d    = write_q;
        reg_d      = reg_q;
        num_d      = num_q;
        wdata_d    = wdata_q;
        ax_d       = ax_q;
        ay_d       = ay_q;
        az_d       = az_q;
        valid_d    = 1'b0;
        to_pulse_d = 1'b0;
        overrun_d  = overrun_q;
        err_cnt_d  = err_cnt_q;

        // Poll timebase only runs once the sensor is configured
        poll_run   = (state_q != ST_IDLE) && (state_q != ST_INIT_REQ) && (state_q != ST_INIT_WAIT);
        tick       = poll_run && (poll_cnt_q == POLL_LAST);
        poll_cnt_d = (!poll_run || tick) ? '0 : poll_cnt_q + 1'b1;

        // Watchdog counts every cycle a transaction is outstanding
        in_txn   = (state_q == ST_INIT_REQ) || (state_q == ST_INIT_WAIT) ||
                   (state_q == ST_READ_REQ) || (state_q == ST_READ_WAIT);
        to_hit   = in_txn && (to_cnt_q == TO_LAST);
        to_cnt_d = in_txn ? to_cnt_q + 1'b1 : to_cnt_q;

        // A poll tick that finds a read still outstanding means samples fell behind
        if (tick && ((state_q == ST_READ_REQ) || (state_q == ST_READ_WAIT) || (state_q == ST_LATCH))) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable && i2c_done) begin
                    state_d  = ST_INIT_REQ;
                    start_d  = 1'b1;
                    write_d  = 1'b1;
                    reg_d    = INIT_REG;
                    num_d    = NB_W'(INIT_NUM_BYTES);
                    wdata_d  = {{(8*MAX_BYTES-8){1'b0}}, INIT_VAL};
                    to_cnt_d = '0;
                end
            end
            ST_INIT_REQ, ST_READ_REQ: begin
                // Acceptance wins over a same-cycle timeout
                if (!i2c_done) begin
                    state_d = (state_q == ST_INIT_REQ) ? ST_INIT_WAIT : ST_READ_WAIT;
                    start_d = 1'b0;
                end else if (to_hit) begin
                    state_d    = ST_IDLE;
                    start_d    = 1'b0;
                    to_pulse_d = 1'b1;
                    err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                end
            end
            ST_INIT_WAIT, ST_READ_WAIT: begin
                // Completion wins over a same-cycle timeout
                if (i2c_done) begin
                    if (state_q == ST_INIT_WAIT) begin
                        state_d = enable ? ST_POLL_WAIT : ST_IDLE;
                    end else begin
                        state_d = ST_LATCH;
                        ax_d    = unp_x;
                        ay_d    = unp_y;
                        az_d    = unp_z;
                        valid_d = 1'b1;
                    end
                end else if (to_hit) begin
                    state_d    = ST_IDLE;
                    start_d    = 1'b0;
                    to_pulse_d = 1'b1;
                    err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                end
            end
            ST_POLL_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    state_d  = ST_READ_REQ;
                    start_d  = 1'b1;
                    write_d  = 1'b0;
                    reg_d    = DATA_REG;
                    num_d    = NB_W'(READ_NUM_BYTES);
                    to_cnt_d = '0;
                end
            end
            ST_LATCH: begin
                state_d = enable ? ST_POLL_WAIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            write_q    <= 1'b0;
            reg_q      <= '0;
            num_q      <= '0;
            wdata_q    <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            az_q       <= '0;
            valid_q    <= 1'b0;
            to_pulse_q <= 1'b0;
            overrun_q  <= 1'b0;
            err_cnt_q  <= '0;
            poll_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            write_q    <= write_d;
            reg_q      <= reg_d;
            num_q      <= num_d;
            wdata_q    <= wdata_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            az_q       <= az_d;
            valid_q    <= valid_d;
            to_pulse_q <= to_pulse_d;
            overrun_q  <= overrun_d;
            err_cnt_q  <= err_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign i2c_start     = start_q;
    assign i2c_write     = write_q;
    assign i2c_dev_addr  = DEV_ADDR;
    assign i2c_reg_addr  = reg_q;
    assign i2c_num_bytes = num_q;
    assign i2c_wdata     = wdata_q;
    assign accel_x       = ax_q;
    assign accel_y       = ay_q;
    assign accel_z       = az_q;
    assign sample_valid  = valid_q;
    assign err_timeout   = to_pulse_q;
    assign overrun       = overrun_q;
    assign err_count     = err_cnt_q;

endmodule
